// File: rtl/otter_hazard_pkg.sv
// Shared types and constants for the OTTER hazard controller.
// Optional build macro: HAZ_PERF_CNT_EN (adds performance counters to the top).
package otter_hazard_pkg;

    // Forwarding mux select driven to the decode-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register file value
        FWD_EX  = 2'b01,   // EX-stage ALU result
        FWD_MEM = 2'b10,   // MEM-stage result
        FWD_PC4 = 2'b11    // MEM-stage PC+4 (JAL/JALR link value)
    } fwd_sel_e;

    // Stall controller states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MWAIT    = 2'd2
    } haz_state_e;

    // Opcodes the surrounding pipeline decodes into ex_is_load / mem_is_jal.
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

endpackage

// File: rtl/otter_fwd_sel.sv
// Combinational forward-select for one decode-stage source operand.
// EX results win over MEM results; x0 and unused operands never forward.
module otter_fwd_sel
    import otter_hazard_pkg::*;
(
    input  logic [4:0] src_adr_i,
    input  logic       src_used_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_regwrite_i,
    input  logic       ex_is_load_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_regwrite_i,
    input  logic       mem_is_jal_i,
    output fwd_sel_e   fsel_o
);

    // Pick the youngest producer; a load in EX has no result yet, so it never forwards.
    always_comb begin
        fsel_o = FWD_RF;
        if (src_used_i && (src_adr_i != 5'd0)) begin
            if (ex_regwrite_i && !ex_is_load_i && (ex_rd_i == src_adr_i)) begin
                fsel_o = FWD_EX;
            end else if (mem_regwrite_i && (mem_rd_i == src_adr_i)) begin
                fsel_o = mem_is_jal_i ? FWD_PC4 : FWD_MEM;
            end
        end
    end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER pipeline hazard controller: operand forwarding, load-use stall
// sequencing with LOAD_LAT bubbles, data-memory wait freeze and EX redirect flush.
// Optional build macro: HAZ_PERF_CNT_EN adds stall/freeze/flush cycle counters.
module otter_hazard_ctrl
    import otter_hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_SRC-1:0][4:0] de_adr,
    input  logic [NUM_SRC-1:0]      de_used,
    input  logic [4:0]              ex_rd,
    input  logic                    ex_regWrite,
    input  logic                    ex_is_load,
    input  logic                    ex_br_taken,
    input  logic [4:0]              mem_rd,
    input  logic                    mem_regWrite,
    input  logic                    mem_is_jal,
    input  logic                    mem_is_load,
    input  logic                    dmem_ready,
    output logic [NUM_SRC-1:0][1:0] fsel,
    output logic                    pc_stall,
    output logic                    de_stall,
    output logic                    ex_bubble,
    output logic                    freeze,
    output logic                    flush_de,
    output logic                    flush_ex
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]             perf_stall_cyc,
    output logic [31:0]             perf_freeze_cyc,
    output logic [31:0]             perf_flush_cnt
`endif
);

    // Remaining bubbles after the first one, loaded when a load-use hazard is seen.
    localparam logic [CNT_W-1:0] LD_RELOAD = CNT_W'(LOAD_LAT - 1);

    haz_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_pend_q, flush_pend_d;

    logic [NUM_SRC-1:0] src_hit;
    fwd_sel_e           fsel_raw [NUM_SRC];
    logic               ld_use;
    logic               mwait;
    logic               stall_c;
    logic               freeze_c;
    logic               flush_c;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            otter_fwd_sel u_fwd (
                .src_adr_i      (de_adr[gi]),
                .src_used_i     (de_used[gi]),
                .ex_rd_i        (ex_rd),
                .ex_regwrite_i  (ex_regWrite),
                .ex_is_load_i   (ex_is_load),
                .mem_rd_i       (mem_rd),
                .mem_regwrite_i (mem_regWrite),
                .mem_is_jal_i   (mem_is_jal),
                .fsel_o         (fsel_raw[gi])
            );
            assign src_hit[gi] = de_used[gi] && (de_adr[gi] == ex_rd);
            assign fsel[gi]    = RST ? FWD_RF : fsel_raw[gi];
        end
    endgenerate

    assign ld_use = ex_is_load && ex_regWrite && (ex_rd != 5'd0) && (|src_hit);
    assign mwait  = mem_is_load && !dmem_ready;

    // Next-state and output decode; in RUN the order is mwait > redirect > load-use.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        stall_c      = 1'b0;
        freeze_c     = 1'b0;
        flush_c      = 1'b0;
        case (state_q)
            RUN: begin
                if (mwait) begin
                    freeze_c = 1'b1;
                    state_d  = MWAIT;
                    // EX is frozen, so a redirect seen now is replayed after the wait.
                    if (ex_br_taken) begin
                        flush_pend_d = 1'b1;
                    end
                end else if (ex_br_taken || flush_pend_q) begin
                    flush_c      = 1'b1;
                    flush_pend_d = 1'b0;
                end else if (ld_use) begin
                    stall_c = 1'b1;
                    if (LOAD_LAT > 1) begin
                        cnt_d   = LD_RELOAD;
                        state_d = LD_STALL;
                    end
                end
            end
            LD_STALL: begin
                // EX holds a bubble here, so any redirect request is spurious.
                if (mwait) begin
                    freeze_c = 1'b1;
                    state_d  = MWAIT;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            MWAIT: begin
                // A redirect only exists if this wait did not interrupt a load-use stall.
                if (ex_br_taken && (cnt_q == '0)) begin
                    flush_pend_d = 1'b1;
                end
                if (!dmem_ready) begin
                    freeze_c = 1'b1;
                end else begin
                    state_d = (cnt_q != '0) ? LD_STALL : RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign pc_stall  = stall_c  && !RST;
    assign de_stall  = stall_c  && !RST;
    assign ex_bubble = stall_c  && !RST;
    assign freeze    = freeze_c && !RST;
    assign flush_de  = flush_c  && !RST;
    assign flush_ex  = flush_c  && !RST;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_freeze_q;
    logic [31:0] perf_flush_q;

    // Free-running event counters, wrapping naturally at 2**32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_stall_q  <= '0;
            perf_freeze_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (de_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (freeze) begin
                perf_freeze_q <= perf_freeze_q + 32'd1;
            end
            if (flush_de) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cyc  = perf_stall_q;
    assign perf_freeze_cyc = perf_freeze_q;
    assign perf_flush_cnt  = perf_flush_q;
`endif

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Scoreboard bench for otter_hazard_ctrl (NUM_SRC=2, LOAD_LAT=3).
// Stimulus pushes expected responses from an "owed bubbles" reference model;
// a negedge monitor pops and compares every cycle.
module tb_otter_hazard_ctrl;

    localparam int NUM_SRC  = 2;
    localparam int LOAD_LAT = 3;
    localparam int CNT_W    = 3;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [NUM_SRC-1:0][4:0] de_adr;
    logic [NUM_SRC-1:0]      de_used;
    logic [4:0]              ex_rd;
    logic                    ex_regWrite, ex_is_load, ex_br_taken;
    logic [4:0]              mem_rd;
    logic                    mem_regWrite, mem_is_jal, mem_is_load, dmem_ready;
    logic [NUM_SRC-1:0][1:0] fsel;
    logic                    pc_stall, de_stall, ex_bubble, freeze, flush_de, flush_ex;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]             perf_stall_cyc, perf_freeze_cyc, perf_flush_cnt;
`endif

    otter_hazard_ctrl #(.NUM_SRC(NUM_SRC), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .de_adr       (de_adr),
        .de_used      (de_used),
        .ex_rd        (ex_rd),
        .ex_regWrite  (ex_regWrite),
        .ex_is_load   (ex_is_load),
        .ex_br_taken  (ex_br_taken),
        .mem_rd       (mem_rd),
        .mem_regWrite (mem_regWrite),
        .mem_is_jal   (mem_is_jal),
        .mem_is_load  (mem_is_load),
        .dmem_ready   (dmem_ready),
        .fsel         (fsel),
        .pc_stall     (pc_stall),
        .de_stall     (de_stall),
        .ex_bubble    (ex_bubble),
        .freeze       (freeze),
        .flush_de     (flush_de),
        .flush_ex     (flush_ex)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_freeze_cyc (perf_freeze_cyc),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic                    rst;
        logic [NUM_SRC-1:0][4:0] adr;
        logic [NUM_SRC-1:0]      used;
        logic [4:0]              ex_rd;
        logic                    ex_rw;
        logic                    ex_ld;
        logic                    br;
        logic [4:0]              mem_rd;
        logic                    mem_rw;
        logic                    mem_jal;
        logic                    mem_ld;
        logic                    rdy;
    } stim_t;

    // ctrl = {pc_stall, de_stall, ex_bubble, freeze, flush_de, flush_ex}
    typedef struct packed {
        logic [NUM_SRC-1:0][1:0] fsel;
        logic [5:0]              ctrl;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    fails  = 0;
    int    txn    = 0;
    int    bub_tally = 0;

    // Reference model state: bubbles still owed, memory wait in progress, redirect owed.
    int    owed = 0;
    bit    in_wait = 1'b0;
    bit    flush_owed = 1'b0;

`ifdef HAZ_PERF_CNT_EN
    logic [96:0] perf_q[$];
    logic [31:0] m_stall = 0, m_freeze = 0, m_flush = 0;
    bit          perf_known = 1'b0;
`endif

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] fwd_ref(input stim_t s, input int i);
        if (!s.used[i] || s.adr[i] == 5'd0) return 2'b00;
        if (s.ex_rw && !s.ex_ld && s.ex_rd == s.adr[i]) return 2'b01;
        if (s.mem_rw && s.mem_rd == s.adr[i]) return s.mem_jal ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    task automatic step(input stim_t s, input string nm);
        exp_t e;
        bit   ld_use, mwait, stall, frz, fl;
        @(posedge CLK);
        #1;
        RST          = s.rst;
        de_adr       = s.adr;
        de_used      = s.used;
        ex_rd        = s.ex_rd;
        ex_regWrite  = s.ex_rw;
        ex_is_load   = s.ex_ld;
        ex_br_taken  = s.br;
        mem_rd       = s.mem_rd;
        mem_regWrite = s.mem_rw;
        mem_is_jal   = s.mem_jal;
        mem_is_load  = s.mem_ld;
        dmem_ready   = s.rdy;

        ld_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (s.used[i] && s.adr[i] == s.ex_rd) ld_use = 1'b1;
        ld_use = ld_use && s.ex_ld && s.ex_rw && (s.ex_rd != 5'd0);
        mwait  = s.mem_ld && !s.rdy;
        stall = 1'b0; frz = 1'b0; fl = 1'b0;
        e = '0;
        if (s.rst) begin
            owed = 0; in_wait = 1'b0; flush_owed = 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) e.fsel[i] = fwd_ref(s, i);
            if (in_wait) begin
                if (owed == 0 && s.br) flush_owed = 1'b1;
                if (!s.rdy) frz = 1'b1;
                else in_wait = 1'b0;
            end else if (mwait) begin
                frz = 1'b1;
                in_wait = 1'b1;
                if (owed == 0 && s.br) flush_owed = 1'b1;
            end else if (owed > 0) begin
                stall = 1'b1;
                owed--;
            end else if (s.br || flush_owed) begin
                fl = 1'b1;
                flush_owed = 1'b0;
            end else if (ld_use) begin
                stall = 1'b1;
                owed = LOAD_LAT - 1;
            end
        end
        e.ctrl = {stall, stall, stall, frz, fl, fl};
        exp_q.push_back(e);
        name_q.push_back(nm);
`ifdef HAZ_PERF_CNT_EN
        perf_q.push_back({perf_known, m_stall, m_freeze, m_flush});
        if (s.rst) begin
            m_stall = 0; m_freeze = 0; m_flush = 0; perf_known = 1'b1;
        end else begin
            m_stall  = m_stall  + 32'(stall);
            m_freeze = m_freeze + 32'(frz);
            m_flush  = m_flush  + 32'(fl);
        end
`endif
    endtask

    // Wait (bounded) for the monitor to consume every pushed expectation.
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
    endtask

    task automatic check_bubbles(input string nm, input int want);
        drain();
        checks++;
        if (bub_tally != want) begin
            fails++;
            $display("FAIL %s: bubble total %0d, required %0d", nm, bub_tally, want);
        end else begin
            $display("bubble total %s = %0d ok", nm, bub_tally);
        end
        bub_tally = 0;
    endtask

    // Monitor: one comparison set per cycle, sampled on the falling edge.
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string nm;
            logic [5:0] got;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {pc_stall, de_stall, ex_bubble, freeze, flush_de, flush_ex};
            txn++;
            if (ex_bubble === 1'b1) bub_tally++;
            checks++;
            if (fsel !== e.fsel) begin
                fails++;
                $display("FAIL fsel txn %0d (%s): got %h required %h", txn, nm, fsel, e.fsel);
            end
            checks++;
            if (got !== e.ctrl) begin
                fails++;
                $display("FAIL ctrl txn %0d (%s): got %b required %b", txn, nm, got, e.ctrl);
            end
            if (freeze === 1'b1 && flush_de === 1'b1) begin
                fails++;
                $display("FAIL excl txn %0d (%s): freeze and flush both high", txn, nm);
            end
            checks++;
`ifdef HAZ_PERF_CNT_EN
            begin
                logic [96:0] p;
                p = perf_q.pop_front();
                if (p[96]) begin
                    checks++;
                    if ({perf_stall_cyc, perf_freeze_cyc, perf_flush_cnt} !== p[95:0]) begin
                        fails++;
                        $display("FAIL perf txn %0d (%s): got %h required %h", txn, nm,
                                 {perf_stall_cyc, perf_freeze_cyc, perf_flush_cnt}, p[95:0]);
                    end
                end
            end
`endif
            $display("txn %0d %-10s fsel=%h ctrl=%b", txn, nm, fsel, got);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        // Hold inputs quiet (reset asserted) until the first driven cycle.
        s = idle();
        s.rst = 1'b1;
        {RST, de_adr, de_used, ex_rd, ex_regWrite, ex_is_load, ex_br_taken,
         mem_rd, mem_regWrite, mem_is_jal, mem_is_load, dmem_ready} = s;

        // Reset with busy inputs: everything must read 0.
        s = idle(); s.rst = 1'b1; s.adr[0] = 5'd5; s.used = 2'b11; s.ex_rd = 5'd5; s.ex_rw = 1'b1;
        s.br = 1'b1; s.mem_ld = 1'b1; s.rdy = 1'b0;
        step(s, "reset");
        step(s, "reset");

        // Forwarding from EX, and x0 never forwards.
        s = idle(); s.adr[0] = 5'd5; s.used[0] = 1'b1; s.ex_rd = 5'd5; s.ex_rw = 1'b1;
        step(s, "fwd_ex");
        s.adr[0] = 5'd0; s.ex_rd = 5'd0;
        step(s, "fwd_x0");

        // MEM JAL -> PC+4, MEM ALU -> MEM, EX beats MEM.
        s = idle(); s.adr[1] = 5'd1; s.used[1] = 1'b1; s.mem_rd = 5'd1; s.mem_rw = 1'b1; s.mem_jal = 1'b1;
        step(s, "fwd_pc4");
        s.mem_jal = 1'b0;
        step(s, "fwd_mem");
        s.ex_rd = 5'd1; s.ex_rw = 1'b1;
        step(s, "fwd_exmem");
        check_bubbles("no_haz", 0);

        // Load-use on x7: exactly LOAD_LAT stall cycles.
        s = idle(); s.adr[0] = 5'd7; s.used[0] = 1'b1; s.ex_rd = 5'd7; s.ex_rw = 1'b1; s.ex_ld = 1'b1;
        step(s, "ld_use");
        s = idle(); s.mem_ld = 1'b1;
        step(s, "ld_stall");
        s = idle();
        for (int i = 0; i < 3; i++) step(s, "ld_tail");
        check_bubbles("ld_use", LOAD_LAT);

        // Same operand but not used: no stall.
        s = idle(); s.adr[0] = 5'd7; s.ex_rd = 5'd7; s.ex_rw = 1'b1; s.ex_ld = 1'b1;
        step(s, "ld_unused");
        check_bubbles("ld_unused", 0);

        // Memory wait of 4 cycles interrupting a load-use stall.
        s = idle(); s.adr[1] = 5'd7; s.used[1] = 1'b1; s.ex_rd = 5'd7; s.ex_rw = 1'b1; s.ex_ld = 1'b1;
        step(s, "ld_use");
        s = idle(); s.mem_ld = 1'b1; s.rdy = 1'b0;
        for (int i = 0; i < 4; i++) step(s, "mwait");
        s.rdy = 1'b1;
        step(s, "mready");
        s = idle();
        for (int i = 0; i < 4; i++) step(s, "resume");
        check_bubbles("ld_mwait", LOAD_LAT);

        // Redirect overrides a simultaneous load-use.
        s = idle(); s.adr[0] = 5'd9; s.used[0] = 1'b1; s.ex_rd = 5'd9; s.ex_rw = 1'b1; s.ex_ld = 1'b1; s.br = 1'b1;
        step(s, "br_lduse");
        s = idle();
        step(s, "br_after");
        check_bubbles("br_lduse", 0);

        // Redirect during a memory wait is issued the cycle after dmem_ready.
        s = idle(); s.mem_ld = 1'b1; s.rdy = 1'b0;
        step(s, "mw_enter");
        s.br = 1'b1;
        step(s, "mw_br");
        s.rdy = 1'b1;
        step(s, "mw_ready");
        s = idle();
        step(s, "mw_flush");
        step(s, "mw_after");

        // Reset in the middle of a load-use stall (counter at 2).
        s = idle(); s.adr[0] = 5'd3; s.used[0] = 1'b1; s.ex_rd = 5'd3; s.ex_rw = 1'b1; s.ex_ld = 1'b1;
        step(s, "ld_use");
        s = idle(); s.rst = 1'b1;
        step(s, "rst_mid");
        s = idle();
        step(s, "post_rst");
        step(s, "post_rst");
        check_bubbles("rst_mid", 1);

        // Randomised traffic with small register numbers to force collisions.
        for (int n = 0; n < 400; n++) begin
            s = '0;
            s.rst = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NUM_SRC; i++) begin
                s.adr[i]  = 5'($urandom_range(0, 3));
                s.used[i] = 1'($urandom_range(0, 1));
            end
            s.ex_rd   = 5'($urandom_range(0, 3));
            s.ex_rw   = 1'($urandom_range(0, 1));
            s.ex_ld   = ($urandom_range(0, 2) == 0);
            s.br      = ($urandom_range(0, 7) == 0);
            s.mem_rd  = 5'($urandom_range(0, 3));
            s.mem_rw  = 1'($urandom_range(0, 1));
            s.mem_jal = ($urandom_range(0, 3) == 0);
            s.mem_ld  = ($urandom_range(0, 2) == 0);
            s.rdy     = ($urandom_range(0, 3) != 0);
            step(s, "random");
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
